// File: rtl/spi_seq_pkg.sv
// spi_seq_pkg: shared state type and constants for the SPI byte sequencer
package spi_seq_pkg;
  typedef enum logic [2:0] {IDLE, LEAD, LO, HI, TRAIL} state_t;
  localparam logic [1:0] SS_NONE = 2'b11;
  localparam int DIVBITS_DEF = 4;
endpackage

// File: rtl/spi_halfdiv.sv
// spi_halfdiv: half-period down-counter, tick is high on the last cycle of a phase
module spi_halfdiv
  import spi_seq_pkg::*;
#(
  parameter int DIVBITS = DIVBITS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DIVBITS-1:0] div,
  output logic               tick
);
  localparam logic [DIVBITS-1:0] ONE = 1;
  logic [DIVBITS-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= div;
    else if (cnt != '0) cnt <= cnt - ONE;
  assign tick = cnt == '0;
endmodule

// File: rtl/spi_seq.sv
// spi_seq: SPI byte shift engine arbitrating the pins with legacy bit-bang writes
module spi_seq
  import spi_seq_pkg::*;
#(
  parameter int DIVBITS = DIVBITS_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               bb_we,
  input  logic               bb_sck,
  input  logic               bb_mosi,
  input  logic [1:0]         bb_ss,
  input  logic               bb_cpol,
  output logic               bb_lost,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [7:0]         cmd_data,
  input  logic [1:0]         cmd_ss,
  input  logic [DIVBITS-1:0] cmd_div,
  input  logic               cmd_last,
  output logic [7:0]         rx_data,
  output logic               rx_valid,
  output logic               busy,
  output logic               misox,
  input  logic [2:0]         MISO,
  output logic               SCK,
  output logic               MOSI,
  output logic [1:0]         nSS
);
  state_t state;
  logic cpol, last_q, tick, accept, load;
  logic [DIVBITS-1:0] div_q;
  logic [2:0] bit_cnt;
  logic [6:0] tx;
  logic [7:0] rx;
  assign misox = (MISO[0] & ~nSS[0]) | (MISO[1] & ~nSS[1]) | (MISO[2] & nSS[0] & nSS[1]);
  assign busy = state != IDLE;
  assign cmd_ready = state == IDLE && !bb_we;
  assign accept = cmd_valid && cmd_ready;
  // every phase boundary reloads the divider, so each phase lasts div+1 cycles
  assign load = accept || (busy && tick);
  spi_halfdiv #(.DIVBITS(DIVBITS)) u_div (
    .clk (CLK),
    .rst (RST),
    .load(load),
    .div (accept ? cmd_div : div_q),
    .tick(tick)
  );
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      SCK <= 1'b0;
      MOSI <= 1'b0;
      nSS <= SS_NONE;
      cpol <= 1'b0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      bb_lost <= 1'b0;
      tx <= '0;
      rx <= '0;
      bit_cnt <= '0;
      div_q <= '0;
      last_q <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      bb_lost <= busy && bb_we;
      case (state)
        IDLE:
          if (bb_we) begin
            SCK <= bb_sck;
            MOSI <= bb_mosi;
            nSS <= bb_ss;
            cpol <= bb_cpol;
          end else if (cmd_valid) begin
            div_q <= cmd_div;
            tx <= cmd_data[6:0];
            last_q <= cmd_last;
            nSS <= cmd_ss;
            MOSI <= cmd_data[7];
            SCK <= cpol;
            bit_cnt <= '0;
            state <= cmd_ss != nSS ? LEAD : LO;
          end
        LEAD: if (tick) state <= LO;
        LO:
          if (tick) begin
            SCK <= ~cpol;
            rx <= {rx[6:0], misox};
            state <= HI;
          end
        HI:
          if (tick) begin
            SCK <= cpol;
            if (bit_cnt == 3'd7) begin
              rx_data <= rx;
              rx_valid <= 1'b1;
              state <= last_q ? TRAIL : IDLE;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              MOSI <= tx[6];
              tx <= {tx[5:0], 1'b0};
              state <= LO;
            end
          end
        TRAIL:
          if (tick) begin
            nSS <= SS_NONE;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
